// File: rtl/triggered_burst_generator.sv
// Triggered burst generator: rising edge of i_Signal starts 1..N pulses.
// Define TRIG_SYNC_EN to add a 2-flop input synchronizer (+2 cycles latency).
module triggered_burst_generator #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Signal,
  input  logic [CNT_W-1:0] i_Offset,
  input  logic [CNT_W-1:0] i_Width,
  input  logic [CNT_W-1:0] i_Gap,
  input  logic [NUM_W-1:0] i_Count,
  input  logic             i_Retrig,
  output logic             o_Impulse,
  output logic             o_busy,
  output logic             o_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_HIGH,
    S_GAP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  logic sig_in;

`ifdef TRIG_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d = {sync_q[0], i_Signal};

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sig_in = sync_q[1];
`else
  assign sig_in = i_Signal;
`endif

  // History resets high so a level already asserted at release is ignored
  logic sig_q, sig_d;
  logic hist_q, hist_d;
  logic trig;

  assign sig_d  = sig_in;
  assign hist_d = sig_q;
  assign trig   = sig_q & ~hist_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             imp_q, imp_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;

  logic [CNT_W-1:0] wid_in;
  logic [CNT_W-1:0] gap_in;
  logic [NUM_W-1:0] num_in;
  logic             accept;

  assign wid_in = (i_Width == '0) ? CNT_ONE : i_Width;
  assign gap_in = (i_Gap == '0) ? CNT_ONE : i_Gap;
  assign num_in = (i_Count == '0) ? NUM_ONE : i_Count;
  assign accept = trig & ((state_q == S_IDLE) | i_Retrig);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    off_d   = off_q;
    wid_d   = wid_q;
    gap_d   = gap_q;
    num_d   = num_q;
    imp_d   = imp_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;

    if (accept) begin
      off_d   = i_Offset;
      wid_d   = wid_in;
      gap_d   = gap_in;
      num_d   = num_in;
      cnt_d   = '0;
      pulse_d = '0;
      busy_d  = 1'b1;
      if (i_Offset == '0) begin
        state_d = S_HIGH;
        imp_d   = 1'b1;
      end else begin
        state_d = S_DELAY;
        imp_d   = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
        end
        S_DELAY: begin
          if (cnt_q == off_q - CNT_ONE) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            imp_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (cnt_q == wid_q - CNT_ONE) begin
            cnt_d = '0;
            imp_d = 1'b0;
            if (pulse_q == num_q - NUM_ONE) begin
              state_d = S_IDLE;
              pulse_d = '0;
              busy_d  = 1'b0;
              rdy_d   = 1'b1;
            end else begin
              state_d = S_GAP;
              pulse_d = pulse_q + NUM_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q == gap_q - CNT_ONE) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            imp_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sig_q   <= 1'b1;
      hist_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
      off_q   <= '0;
      wid_q   <= '0;
      gap_q   <= '0;
      num_q   <= '0;
      imp_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      sig_q   <= sig_d;
      hist_q  <= hist_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      off_q   <= off_d;
      wid_q   <= wid_d;
      gap_q   <= gap_d;
      num_q   <= num_d;
      imp_q   <= imp_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign o_Impulse = imp_q;
  assign o_busy    = busy_q;
  assign o_ready   = rdy_q;

endmodule

// File: tb/tb_triggered_burst_generator.sv
// Scoreboard bench: expected output edges queued by stimulus,
// matched by a negedge monitor against observed edges.
module tb_triggered_burst_generator;

`ifdef TRIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int KBR = 0;
  localparam int KBF = 1;
  localparam int KIR = 2;
  localparam int KIF = 3;
  localparam int KRR = 4;
  localparam int KRF = 5;

  typedef struct {
    int     kind;
    longint cyc;
  } ev_t;

  ev_t exp_q[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sig = 1'b0;
  logic [15:0] off = '0;
  logic [15:0] wid = '0;
  logic [15:0] gap = '0;
  logic [7:0]  cnt = '0;
  logic        retrig = 1'b0;
  logic        imp;
  logic        busy;
  logic        rdy;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint k;
  logic   pb = 1'b0;
  logic   pi = 1'b0;
  logic   pr = 1'b0;

  triggered_burst_generator dut (
    .i_Clk    (clk),
    .i_Rst_n  (rst_n),
    .i_Signal (sig),
    .i_Offset (off),
    .i_Width  (wid),
    .i_Gap    (gap),
    .i_Count  (cnt),
    .i_Retrig (retrig),
    .o_Impulse(imp),
    .o_busy   (busy),
    .o_ready  (rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input longint c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none",
               kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d cycle %0d, expected kind %0d cycle %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [5:0] ev;
    ev[KBR] = busy & ~pb;
    ev[KBF] = ~busy & pb;
    ev[KIR] = imp & ~pi;
    ev[KIF] = ~imp & pi;
    ev[KRR] = rdy & ~pr;
    ev[KRF] = ~rdy & pr;
    for (int i = 0; i < 6; i++) begin
      if (ev[i]) see(i);
    end
    pb <= busy;
    pi <= imp;
    pr <= rdy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic arm();
    sig = 1'b0;
    tick(3 + LAT);
  endtask

  task automatic cfg(input logic [15:0] o, input logic [15:0] w,
                     input logic [15:0] g, input logic [7:0] c,
                     input logic r);
    off    = o;
    wid    = w;
    gap    = g;
    cnt    = c;
    retrig = r;
  endtask

  initial begin
    // reset with trigger level already high
    sig = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_imp", imp, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rdy", rdy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(50);
    chk("idle_imp", imp, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_rdy", rdy, 1'b0);

    // single wide pulse, config changed mid-burst
    arm();
    cfg(16'd1, 16'd20, 16'd5, 8'd1, 1'b0);
    k = cyc + 1 + LAT;
    sig = 1'b1;
    push(KBR, k + 1);
    push(KIR, k + 2);
    push(KBF, k + 22);
    push(KIF, k + 22);
    push(KRR, k + 22);
    push(KRF, k + 23);
    tick(2 + LAT);
    cfg(16'd0, 16'd5, 16'd1, 8'd3, 1'b0);
    drain("single_pulse", 60);

    // four pulses, offset 0
    arm();
    cfg(16'd0, 16'd3, 16'd2, 8'd4, 1'b0);
    k = cyc + 1 + LAT;
    sig = 1'b1;
    push(KBR, k + 1);
    push(KIR, k + 1);
    push(KIF, k + 4);
    push(KIR, k + 6);
    push(KIF, k + 9);
    push(KIR, k + 11);
    push(KIF, k + 14);
    push(KIR, k + 16);
    push(KBF, k + 19);
    push(KIF, k + 19);
    push(KRR, k + 19);
    push(KRF, k + 20);
    drain("burst4", 60);

    // second edge mid-burst, retrigger disabled
    arm();
    cfg(16'd0, 16'd3, 16'd2, 8'd4, 1'b0);
    k = cyc + 1 + LAT;
    sig = 1'b1;
    push(KBR, k + 1);
    push(KIR, k + 1);
    push(KIF, k + 4);
    push(KIR, k + 6);
    push(KIF, k + 9);
    push(KIR, k + 11);
    push(KIF, k + 14);
    push(KIR, k + 16);
    push(KBF, k + 19);
    push(KIF, k + 19);
    push(KRR, k + 19);
    push(KRF, k + 20);
    tick(3);
    sig = 1'b0;
    tick(4);
    sig = 1'b1;
    drain("retrig_off", 60);

    // same stimulus, retrigger enabled: restart while HIGH
    arm();
    cfg(16'd0, 16'd3, 16'd2, 8'd4, 1'b1);
    k = cyc + 1 + LAT;
    sig = 1'b1;
    push(KBR, k + 1);
    push(KIR, k + 1);
    push(KIF, k + 4);
    push(KIR, k + 6);
    push(KIF, k + 11);
    push(KIR, k + 13);
    push(KIF, k + 16);
    push(KIR, k + 18);
    push(KIF, k + 21);
    push(KIR, k + 23);
    push(KBF, k + 26);
    push(KIF, k + 26);
    push(KRR, k + 26);
    push(KRF, k + 27);
    tick(3);
    sig = 1'b0;
    tick(4);
    sig = 1'b1;
    drain("retrig_on", 60);

    // zero config clamps to one pulse; trigger in ready cycle
    arm();
    cfg(16'd0, 16'd0, 16'd0, 8'd0, 1'b0);
    k = cyc + 1 + LAT;
    sig = 1'b1;
    push(KBR, k + 1);
    push(KIR, k + 1);
    push(KBF, k + 2);
    push(KIF, k + 2);
    push(KRR, k + 2);
    push(KBR, k + 3);
    push(KIR, k + 3);
    push(KRF, k + 3);
    push(KBF, k + 4);
    push(KIF, k + 4);
    push(KRR, k + 4);
    push(KRF, k + 5);
    tick(1);
    sig = 1'b0;
    tick(1);
    sig = 1'b1;
    drain("zero_cfg", 30);

    // offset 5, two pulses
    arm();
    cfg(16'd5, 16'd2, 16'd1, 8'd2, 1'b0);
    k = cyc + 1 + LAT;
    sig = 1'b1;
    push(KBR, k + 1);
    push(KIR, k + 6);
    push(KIF, k + 8);
    push(KIR, k + 9);
    push(KBF, k + 11);
    push(KIF, k + 11);
    push(KRR, k + 11);
    push(KRF, k + 12);
    drain("offset5", 40);

    // async reset mid-HIGH
    arm();
    cfg(16'd1, 16'd20, 16'd1, 8'd1, 1'b0);
    k = cyc + 1 + LAT;
    sig = 1'b1;
    push(KBR, k + 1);
    push(KIR, k + 2);
    tick(6 + LAT);
    chk("mid_high_imp", imp, 1'b1);
    push(KBF, k + 5);
    push(KIF, k + 5);
    #1 rst_n = 1'b0;
    #1;
    chk("async_imp", imp, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_rdy", rdy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(30);
    drain("async_reset", 5);
    chk("post_reset_imp", imp, 1'b0);
    chk("post_reset_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
